// File: rtl/baud_pkg.sv
// baud_pkg: shared widths, legal code limit, baud code names and scheduler states
package baud_pkg;
    localparam int PERIOD_W = 19;
    localparam logic [3:0] MAX_CODE = 4'hB;
    localparam logic [3:0] B300    = 4'h0;
    localparam logic [3:0] B1200   = 4'h1;
    localparam logic [3:0] B2400   = 4'h2;
    localparam logic [3:0] B4800   = 4'h3;
    localparam logic [3:0] B9600   = 4'h4;
    localparam logic [3:0] B19200  = 4'h5;
    localparam logic [3:0] B38400  = 4'h6;
    localparam logic [3:0] B57600  = 4'h7;
    localparam logic [3:0] B115200 = 4'h8;
    localparam logic [3:0] B230400 = 4'h9;
    localparam logic [3:0] B460800 = 4'hA;
    localparam logic [3:0] B921600 = 4'hB;
    typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, LOAD = 2'd2} state_t;
endpackage

// File: rtl/baud_sched_if.sv
// baud_sched_if: host config, busy/sync inputs, baud decoder link and tick outputs
//   slave  : the scheduler (drives baud_sel, cfg_pending, cfg_err, ticks)
//   master : host / UART side (drives cfg_*, busy flags, rx_sync, bit_period)
interface baud_sched_if #(
    parameter int PERIOD_W = baud_pkg::PERIOD_W
);
    logic                cfg_we;
    logic [3:0]          cfg_baud;
    logic                tx_busy;
    logic                rx_busy;
    logic                rx_sync;
    logic [PERIOD_W-1:0] bit_period;
    logic [3:0]          baud_sel;
    logic                cfg_pending;
    logic                cfg_err;
    logic                bit_tick;
    logic                half_tick;
    logic                os_tick;
    modport slave (
        input  cfg_we, cfg_baud, tx_busy, rx_busy, rx_sync, bit_period,
        output baud_sel, cfg_pending, cfg_err, bit_tick, half_tick, os_tick
    );
    modport master (
        output cfg_we, cfg_baud, tx_busy, rx_busy, rx_sync, bit_period,
        input  baud_sel, cfg_pending, cfg_err, bit_tick, half_tick, os_tick
    );
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period counter producing registered bit/half/16x ticks
//   clk, reset : clock, synchronous active-high reset
//   period     : clocks per bit (0 or 1 treated as 2)
//   clear      : restart counters and suppress this cycle's ticks
//   enable     : counting active; ticks held low otherwise
//   bit_tick, half_tick, os_tick : one-cycle pulses, one cycle after the compare
//   Macro BAUD_OS16_EN builds the 16x oversample counter; otherwise os_tick=0.
module baud_tick_gen #(
    parameter int PERIOD_W = baud_pkg::PERIOD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clear,
    input  logic                enable,
    output logic                bit_tick,
    output logic                half_tick,
    output logic                os_tick
);
    import baud_pkg::*;

    logic [PERIOD_W-1:0] per, cnt;
    logic                wrap;

    assign per  = period < PERIOD_W'(2) ? PERIOD_W'(2) : period;
    // >= keeps the counter bounded even if it somehow overshoots the period
    assign wrap = cnt >= per - 1'b1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt       <= '0;
            bit_tick  <= 1'b0;
            half_tick <= 1'b0;
        end else if (enable) begin
            cnt       <= wrap ? '0 : cnt + 1'b1;
            bit_tick  <= wrap;
            half_tick <= cnt == (per >> 1) - 1'b1;
        end else begin
            bit_tick  <= 1'b0;
            half_tick <= 1'b0;
        end
    end

`ifdef BAUD_OS16_EN
    logic [PERIOD_W-5:0] div, os_cnt;
    logic                os_wrap;

    assign div     = per[PERIOD_W-1:4] == '0 ? (PERIOD_W-4)'(1) : per[PERIOD_W-1:4];
    assign os_wrap = os_cnt >= div - 1'b1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            os_cnt  <= '0;
            os_tick <= 1'b0;
        end else if (enable) begin
            os_cnt  <= os_wrap ? '0 : os_cnt + 1'b1;
            os_tick <= os_wrap;
        end else begin
            os_tick <= 1'b0;
        end
    end
`else
    assign os_tick = 1'b0;
`endif
endmodule

// File: rtl/baud_sched.sv
// baud_sched: baud-rate scheduler; applies host rate changes when TX/RX idle and
// generates bit/half/oversample ticks, re-phased by RX start-edge sync.
//   clk, reset : 100 MHz clock, synchronous active-high reset
//   bus        : baud_sched_if.slave (config strobe/code, busy flags, rx_sync,
//                bit_period in; baud_sel, cfg_pending, cfg_err, ticks out)
//   Macro BAUD_OS16_EN enables the 16x oversample tick (os_tick=0 otherwise).
module baud_sched #(
    parameter logic [3:0] RESET_BAUD = baud_pkg::B9600,
    parameter int         PERIOD_W   = baud_pkg::PERIOD_W,
    parameter logic [3:0] MAX_CODE   = baud_pkg::MAX_CODE
) (
    input  logic         clk,
    input  logic         reset,
    baud_sched_if.slave  bus
);
    import baud_pkg::*;

    state_t              state;
    logic [3:0]          pend_code;
    logic [PERIOD_W-1:0] period_q;
    logic                err_q;
    logic                legal_we, apply;

    assign legal_we = bus.cfg_we && bus.cfg_baud <= MAX_CODE;
    // a fresh legal write in the idle cycle beats applying the pending code
    assign apply    = state == PEND && !bus.tx_busy && !bus.rx_busy && !legal_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD;
            bus.baud_sel <= RESET_BAUD;
            pend_code    <= '0;
            period_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            err_q <= bus.cfg_we && bus.cfg_baud > MAX_CODE;
            if (legal_we) begin
                pend_code <= bus.cfg_baud;
            end
            if (apply) begin
                bus.baud_sel <= pend_code;
            end
            // decoder output already reflects the baud_sel written on entry to LOAD
            if (state == LOAD) begin
                period_q <= bus.bit_period;
            end
            state <= legal_we ? PEND : apply ? LOAD : state == LOAD ? IDLE : state;
        end
    end

    assign bus.cfg_pending = state == PEND;
    assign bus.cfg_err     = err_q;

    baud_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .period    (period_q),
        .clear     (state == LOAD || bus.rx_sync),
        .enable    (state != LOAD),
        .bit_tick  (bus.bit_tick),
        .half_tick (bus.half_tick),
        .os_tick   (bus.os_tick)
    );
endmodule

// File: tb/tb_baud_sched.sv
// tb_baud_sched: randomized scoreboard bench for baud_sched with a timing-level reference model
module tb_baud_sched;
    import baud_pkg::*;

    typedef struct {int t; int v;} ev_t;
    localparam int KB = 0, KH = 1, KO = 2, KE = 3, KP = 4, KS = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    baud_sched_if bus ();
    baud_sched dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    ev_t q[6][$];
    string nm[6] = '{"bit_tick", "half_tick", "os_tick", "cfg_err", "cfg_pending", "baud_sel"};
    bit fault = 0;
    int fault_val = 0;
    bit mon_on = 0;
    int stop_cyc = 1 << 30;
    int t0, p;
    logic [3:0] sel;
    int xc[$];
    logic [3:0] xv[$];

    function automatic int rate(logic [3:0] c);
        int b[12] = '{300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
        return c <= 4'hB ? 100_000_000 / b[c] : 0;
    endfunction

    assign bus.bit_period = fault ? PERIOD_W'(fault_val) : PERIOD_W'(rate(bus.baud_sel));

    task automatic chk(string n, int a, int x);
        checks++;
        if (a != x) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", n, a, x);
        end
    endtask

    task automatic take(int k, int v);
        ev_t e;
        checks++;
        if (q[k].size() == 0) begin
            failures++;
            $display("FAIL %s: unexpected at cycle %0d value %0d, expected nothing", nm[k], cyc, v);
        end else begin
            e = q[k].pop_front();
            if (e.t != cyc || e.v != v) begin
                failures++;
                $display("FAIL %s: got cycle %0d value %0d, expected cycle %0d value %0d", nm[k], cyc, v, e.t, e.v);
            end
        end
    endtask

    logic [3:0] prev_sel = 4'h4;
    logic prev_pend = 1'b0;
    always @(negedge clk) begin
        if (mon_on && cyc <= stop_cyc) begin
            if (bus.bit_tick) take(KB, 1);
            if (bus.half_tick) take(KH, 1);
            if (bus.os_tick) take(KO, 1);
            if (bus.cfg_err) take(KE, 1);
            if (bus.cfg_pending != prev_pend) take(KP, int'(bus.cfg_pending));
            if (bus.baud_sel != prev_sel) take(KS, int'(bus.baud_sel));
            prev_pend = bus.cfg_pending;
            prev_sel = bus.baud_sel;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        bus.rx_sync = 1'b0;
    endtask

    task automatic go(int n);
        while (cyc < n) step();
    endtask

    task automatic push(int k, int t, int v);
        q[k].push_back(ev_t'{t, v});
    endtask

    // Ticks seen at c+1 for each counting cycle c in [s0, x): phase measured from restart s0.
    task automatic push_ticks(int s0, int pr, int x);
        int pe = pr < 2 ? 2 : pr;
        int dv = (pe / 16) < 1 ? 1 : pe / 16;
        for (int c = s0; c < x; c++) begin
            if ((c - s0) % pe == pe - 1) push(KB, c + 1, 1);
            if ((c - s0) % pe == pe / 2 - 1) push(KH, c + 1, 1);
`ifdef BAUD_OS16_EN
            if ((c - s0) % dv == dv - 1) push(KO, c + 1, 1);
`else
            if (dv < 0) push(KO, c + 1, 1);
`endif
        end
    endtask

    function automatic logic [3:0] fast();
        return 4'($urandom_range(7, 11));
    endfunction

    // rx_sync off cycles after restart, optionally preceded by an illegal write
    task automatic do_sync(int off, logic [3:0] bad);
        int s = t0 + off;
        int e;
        push_ticks(t0, p, s);
        if (bad > MAX_CODE && off > 0) begin
            e = t0 + $urandom_range(0, off - 1);
            push(KE, e + 1, 1);
            go(e);
            bus.cfg_we = 1'b1;
            bus.cfg_baud = bad;
        end
        go(s);
        bus.rx_sync = 1'b1;
        t0 = s + 1;
    endtask

    // legal write at t0+w, b busy cycles (extras from xc/xv), optional write in the idle cycle
    task automatic do_cfg(int w, logic [3:0] code, int b, bit late, bit use_rx, bit flt);
        int c = t0 + w;
        int l = c + 2 + b + int'(late);
        logic [3:0] fin = code;
        logic [3:0] lc = fast();
        for (int i = 0; i < xc.size(); i++) begin
            if (xv[i] > MAX_CODE) push(KE, c + xc[i] + 1, 1);
            else fin = xv[i];
        end
        if (late) fin = lc;
        push_ticks(t0, p, l);
        push(KP, c + 1, 1);
        push(KP, l, 0);
        if (fin != sel) push(KS, l, int'(fin));
        go(c);
        fault = flt;
        fault_val = $urandom_range(0, 1);
        bus.cfg_we = 1'b1;
        bus.cfg_baud = code;
        if (b > 0) begin
            if (use_rx) bus.rx_busy = 1'b1;
            else bus.tx_busy = 1'b1;
        end
        for (int i = 0; i < xc.size(); i++) begin
            go(c + xc[i]);
            bus.cfg_we = 1'b1;
            bus.cfg_baud = xv[i];
        end
        go(c + 1 + b);
        bus.tx_busy = 1'b0;
        bus.rx_busy = 1'b0;
        if (late) begin
            bus.cfg_we = 1'b1;
            bus.cfg_baud = lc;
        end
        go(l);
        xc.delete();
        xv.delete();
        sel = fin;
        p = flt ? fault_val : rate(fin);
        t0 = l + 1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int b, e;
        bus.cfg_we = 1'b0;
        bus.cfg_baud = 4'h0;
        bus.tx_busy = 1'b0;
        bus.rx_busy = 1'b0;
        bus.rx_sync = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_baud_sel", int'(bus.baud_sel), 4);
        chk("rst_cfg_pending", int'(bus.cfg_pending), 0);
        chk("rst_cfg_err", int'(bus.cfg_err), 0);
        chk("rst_ticks", int'({bus.bit_tick, bus.half_tick, bus.os_tick}), 0);
        sel = 4'h4;
        p = rate(sel);
        t0 = cyc + 1;
        mon_on = 1'b1;

        do_cfg(2 * p + 10, B115200, 0, 1'b0, 1'b0, 1'b0);
        do_sync(500, 4'hE);
        do_sync(p - 1, 4'h0);
        do_cfg(100, B460800, 5, 1'b0, 1'b0, 1'b0);
        xc = '{1};
        xv = '{B38400};
        do_cfg(50, B4800, 8, 1'b0, 1'b1, 1'b0);
        do_sync(p + 3, 4'hF);
        do_cfg(20, B230400, 3, 1'b1, 1'b0, 1'b0);
        do_cfg(30, B921600, 0, 1'b0, 1'b0, 1'b1);
        do_sync(7, 4'h0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_sync($urandom_range(0, p + 50), $urandom_range(0, 1) == 1 ? 4'($urandom_range(12, 15)) : 4'h0);
            end else begin
                b = $urandom_range(0, 1) == 1 ? $urandom_range(1, 12) : 0;
                for (int i = 1; i <= b; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        xc.push_back(i);
                        xv.push_back(4'($urandom_range(7, 15)));
                    end
                end
                do_cfg($urandom_range(0, p + 50), fast(), b, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
            end
        end

        e = t0 + p + 40;
        push_ticks(t0, p, e);
        stop_cyc = e;
        go(e + 3);
        for (int k = 0; k < 6; k++) chk({nm[k], "_left"}, q[k].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
